// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit operation encoding used on the mode input and its typedef.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_CLR  = 3'd4;
  localparam mode_t MODE_SET  = 3'd5;
  localparam mode_t MODE_ROL  = 3'd6;
  localparam mode_t MODE_ROR  = 3'd7;

endpackage : shift_reg_pkg

// File: rtl/shift_word_cnt.sv
// Word framing counter: counts counted shifts and pulses word_done once per
// WIDTH shifts, streaming back-to-back with no dead cycle.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   en        in   clock enable (0 holds cnt, clears word_done)
//   restart   in   load/clear/set: restart framing at zero
//   step      in   one counted shift this cycle
//   cnt       out  shifts since last boundary/restart
//   word_done out  one-cycle pulse after the WIDTH-th counted shift
module shift_word_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       restart,
  input  logic                       step,
  output logic [$clog2(WIDTH)-1:0]   cnt,
  output logic                       word_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_word_done;

  // Restart wins over step; word_done only rises on the wrap of a counted shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else if (!en) begin
      r_word_done <= 1'b0;
    end else if (restart) begin
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else if (step) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt       <= '0;
        r_word_done <= 1'b1;
      end else begin
        r_cnt       <= r_cnt + CNT_W'(1);
        r_word_done <= 1'b0;
      end
    end else begin
      r_word_done <= 1'b0;
    end
  end

  assign cnt       = r_cnt;
  assign word_done = r_word_done;

endmodule : shift_word_cnt

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with word framing.
// Operations: hold, load, shift left/right, clear, set; optional rotates.
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN enables ROL (mode 6) and
// ROR (mode 7); when undefined those modes behave as HOLD.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   en        in   clock enable; 0 freezes all state
//   mode      in   operation select (shift_reg_pkg MODE_*)
//   sin_l     in   serial in at MSB on shift right
//   sin_r     in   serial in at LSB on shift left
//   d         in   parallel load data
//   q         out  register contents
//   sout_msb  out  q[WIDTH-1]
//   sout_lsb  out  q[0]
//   cnt       out  counted shifts since last boundary/load/clear/set
//   word_done out  one-cycle pulse marking a completed word
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic              sin_l,
  input  logic              sin_r,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic [CNT_W-1:0]  cnt,
  output logic              word_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_restart;
  logic             w_step;
  mode_t            w_mode;

  assign w_mode = mode_t'(mode);

  // Datapath mux plus decode of mode into framing controls.
  always_comb begin
    w_q_nxt   = r_q;
    w_restart = 1'b0;
    w_step    = 1'b0;
    case (w_mode)
      MODE_LOAD: begin
        w_q_nxt   = d;
        w_restart = 1'b1;
      end
      MODE_SHL: begin
        w_q_nxt = {r_q[WIDTH-2:0], sin_r};
        w_step  = 1'b1;
      end
      MODE_SHR: begin
        w_q_nxt = {sin_l, r_q[WIDTH-1:1]};
        w_step  = 1'b1;
      end
      MODE_CLR: begin
        w_q_nxt   = '0;
        w_restart = 1'b1;
      end
      MODE_SET: begin
        w_q_nxt   = '1;
        w_restart = 1'b1;
      end
`ifdef SHIFT_REG_UNIV_ROTATE_EN
      MODE_ROL: begin
        w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_step  = 1'b1;
      end
      MODE_ROR: begin
        w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        w_step  = 1'b1;
      end
`endif
      default: begin
        w_q_nxt = r_q;
      end
    endcase
  end

  // Register contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_q_nxt;
    end
  end

  shift_word_cnt #(
    .WIDTH(WIDTH)
  ) u_word_cnt (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .restart   (w_restart),
    .step      (w_step),
    .cnt       (cnt),
    .word_done (word_done)
  );

  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];

endmodule : shift_reg_univ

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8): arithmetic reference
// model checked every cycle, plus directed literal expectations.
module tb_shift_reg_univ;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic [2:0]   cnt;
  logic         word_done;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .d         (d),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .cnt       (cnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Reference state: value as an integer, shifts since last restart.
  int m_val    = 0;
  int m_shifts = 0;
  int m_wd     = 0;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic model_step(input bit r, input bit e, input int m, input int dd,
                            input int sl, input int sr);
    bit counted;
    counted = 1'b0;
    if (r) begin
      m_val = 0; m_shifts = 0; m_wd = 0;
    end else if (!e) begin
      m_wd = 0;
    end else begin
      case (m)
        1: begin m_val = dd;  m_shifts = 0; end
        2: begin m_val = (m_val * 2 + sr) % 256;          counted = 1'b1; end
        3: begin m_val = m_val / 2 + sl * 128;            counted = 1'b1; end
        4: begin m_val = 0;   m_shifts = 0; end
        5: begin m_val = 255; m_shifts = 0; end
        6: if (ROT) begin m_val = (m_val * 2) % 256 + m_val / 128;   counted = 1'b1; end
        7: if (ROT) begin m_val = m_val / 2 + (m_val % 2) * 128;     counted = 1'b1; end
        default: ;
      endcase
      if (counted) begin
        m_shifts++;
        m_wd = (m_shifts % W == 0) ? 1 : 0;
      end else begin
        m_wd = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic apply(input bit r, input bit e, input int m, input int dd,
                       input int sl, input int sr);
    reset = r; en = e; mode = 3'(m); d = 8'(dd); sin_l = 1'(sl); sin_r = 1'(sr);
    @(posedge clk);
    model_step(r, e, m, dd, sl, sr);
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q",         int'(q),         m_val);
      check("model_cnt",       int'(cnt),       m_shifts % W);
      check("model_word_done", int'(word_done), m_wd);
      check("model_sout_msb",  int'(sout_msb),  m_val / 128);
      check("model_sout_lsb",  int'(sout_lsb),  m_val % 2);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b1; mode = 3'd1; d = 8'hA5; sin_l = 1'b0; sin_r = 1'b0;
    @(negedge clk);

    // Reset priority over LOAD.
    apply(1, 1, 1, 'hA5, 0, 0);
    chk_on = 1'b1;
    apply(1, 1, 1, 'hA5, 0, 0);
    check("rst_q", int'(q), 'h00);
    check("rst_cnt", int'(cnt), 0);
    check("rst_wd", int'(word_done), 0);
    apply(0, 1, 1, 'hA5, 0, 0);
    check("load_q", int'(q), 'hA5);

    // Shift left with sin_r=1.
    apply(0, 1, 2, 0, 0, 1);
    check("shl1_q", int'(q), 'h4B);
    apply(0, 1, 2, 0, 0, 1);
    check("shl2_q", int'(q), 'h97);
    apply(0, 1, 2, 0, 0, 1);
    check("shl3_q", int'(q), 'h2F);
    check("shl3_cnt", int'(cnt), 3);
    check("shl3_msb", int'(sout_msb), 0);

    // Hold then SET.
    apply(0, 1, 0, 0, 1, 1);
    check("hold_q", int'(q), 'h2F);
    check("hold_cnt", int'(cnt), 3);
    apply(0, 1, 5, 0, 0, 0);
    check("set_q", int'(q), 'hFF);
    check("set_cnt", int'(cnt), 0);

    // Word framing with SHR, sin_l=1.
    apply(0, 1, 4, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      apply(0, 1, 3, 0, 1, 0);
      if (i == 7) check("shr7_wd", int'(word_done), 0);
    end
    check("shr8_q", int'(q), 'hFF);
    check("shr8_cnt", int'(cnt), 0);
    check("shr8_wd", int'(word_done), 1);
    apply(0, 1, 3, 0, 1, 0);
    check("shr9_q", int'(q), 'hFF);
    check("shr9_cnt", int'(cnt), 1);
    check("shr9_wd", int'(word_done), 0);

    // Enable freeze mid-word.
    apply(0, 1, 1, 'h00, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 2, 0, 0, i % 2);
    check("frz_pre_cnt", int'(cnt), 5);
    for (int i = 0; i < 3; i++) apply(0, 0, 2, 0, 0, 1);
    check("frz_q", int'(q), 'h0A);
    check("frz_cnt", int'(cnt), 5);
    check("frz_wd", int'(word_done), 0);
    apply(0, 1, 2, 0, 0, 1);
    apply(0, 1, 2, 0, 0, 1);
    check("resume2_wd", int'(word_done), 0);
    apply(0, 1, 2, 0, 0, 1);
    check("resume3_wd", int'(word_done), 1);
    check("resume3_cnt", int'(cnt), 0);

    // Mixed directions still form a word; back-to-back stream.
    for (int i = 0; i < 8; i++) apply(0, 1, (i < 4) ? 2 : 3, 0, 1, 0);
    check("mix_wd", int'(word_done), 1);

    // Rotates (HOLD when the feature is disabled).
    apply(0, 1, 1, 'h81, 0, 0);
    apply(0, 1, 6, 0, 0, 0);
    check("rol_q", int'(q), ROT ? 'h03 : 'h81);
    check("rol_cnt", int'(cnt), ROT ? 1 : 0);
    apply(0, 1, 1, 'h81, 0, 0);
    apply(0, 1, 7, 0, 0, 0);
    check("ror_q", int'(q), ROT ? 'hC0 : 'h81);
    check("ror_cnt", int'(cnt), ROT ? 1 : 0);

    // Mid-word LOAD restarts framing.
    apply(0, 1, 1, 'h00, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 2, 0, 0, 1);
    apply(0, 1, 1, 'h3C, 0, 0);
    check("midld_q", int'(q), 'h3C);
    check("midld_cnt", int'(cnt), 0);
    check("midld_wd", int'(word_done), 0);

    // Reset at cnt=7 suppresses the pending word.
    for (int i = 0; i < 7; i++) apply(0, 1, 3, 0, 0, 0);
    check("pre_rst_cnt", int'(cnt), 7);
    apply(1, 1, 2, 0, 0, 1);
    check("midrst_q", int'(q), 0);
    check("midrst_cnt", int'(cnt), 0);
    check("midrst_wd", int'(word_done), 0);
    apply(0, 1, 2, 0, 0, 1);
    check("postrst_cnt", int'(cnt), 1);
    check("postrst_q", int'(q), 'h01);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_shift_reg_univ

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; successor to the fixed 4-bit serial/parallel shift register.
- Width is generic. Supports hold, parallel load, clear, set, and bidirectional serial shift.
- Counts shifts since the last load/clear and flags each completed word, so it can act as a SIPO/PISO framing stage in serial-link datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), shift-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 freezes all state.
- mode  input  3  operation select (encoding below).
- sin_l  input  1  serial input entering at the MSB on shift right.
- sin_r  input  1  serial input entering at the LSB on shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_msb  output  1  q[WIDTH-1], combinational from q.
- sout_lsb  output  1  q[0], combinational from q.
- cnt  output  CNT_W  number of shifts since the last word boundary, load, clear or set.
- word_done  output  1  registered one-cycle pulse marking a completed word.

Behaviour:
- All state updates on the rising edge of clk. Priority: reset > en=0 > mode.
- Reset (synchronous, active-high): q=0, cnt=0, word_done=0. Reset overrides any operation in progress, including mid-word.
- en=0: q and cnt hold; word_done=0.
- mode encoding (en=1):
  - 0 HOLD: q and cnt hold.
  - 1 LOAD: q<=d; cnt<=0.
  - 2 SHL: q<={q[WIDTH-2:0],sin_r}.
  - 3 SHR: q<={sin_l,q[WIDTH-1:1]}.
  - 4 CLR: q<=0; cnt<=0.
  - 5 SET: q<=all ones; cnt<=0.
  - 6 ROL / 7 ROR: see Optional Feature.
- Shift ops (SHL, SHR, and ROL/ROR when enabled) are "counting" ops:
  - If cnt==WIDTH-1: cnt<=0 and word_done<=1.
  - Otherwise: cnt<=cnt+1 and word_done<=0.
- word_done is high for exactly one cycle, in the cycle after the WIDTH-th counted shift edge, i.e. coincident with q showing the completed word. It is 0 after every non-counting op.
- Consecutive words stream back-to-back: word_done pulses once every WIDTH counted shifts, with no dead cycle.
- Mixing SHL and SHR within a word is legal; both directions count.
- LOAD, CLR and SET restart word framing even when cnt is mid-word; word_done=0 on that edge.

Optional Feature:
- Macro: SHIFT_REG_UNIV_ROTATE_EN.
- Defined:
  - mode 6 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - mode 7 ROR: q<={q[0],q[WIDTH-1:1]}.
  - Both are counting ops, identical to shifts for cnt and word_done.
- Undefined: modes 6 and 7 behave as HOLD (q, cnt unchanged; word_done=0).

Decomposition:
- Package shift_reg_pkg holds the 3-bit mode encoding as named localparams (MODE_HOLD through MODE_ROR) and the mode typedef.
- One sub-module, shift_word_cnt, is natural. It takes clk, reset, en, restart and step; it outputs cnt and word_done. It is parametrised by WIDTH.
- The top level holds the q datapath mux and decodes mode into restart and step.

Test Plan (WIDTH=8 unless stated):
- Reset priority: reset=1, en=1, mode=LOAD, d=8'hA5 for 2 cycles -> q=8'h00, cnt=0, word_done=0; release reset -> next LOAD gives q=8'hA5.
- Shift left: LOAD 8'hA5, then SHL with sin_r=1 for 3 cycles -> q=8'h4B, 8'h97, 8'h2F; cnt=3; sout_msb=0.
- Word framing: CLR, then SHR with sin_l=1 for 8 cycles -> q=8'hFF, cnt=0 and word_done=1 after the 8th edge only; a 9th SHR gives q=8'hFF, cnt=1, word_done=0.
- Enable freeze: during an SHL stream at cnt=5, drop en for 3 cycles -> q and cnt frozen, word_done=0; resume -> word_done fires after 3 more shifts.
- Rotate: LOAD 8'h81, mode=ROL -> q=8'h03, cnt=1 with macro defined; without the macro q=8'h81, cnt=0. Repeat with ROR from 8'h81 -> 8'hC0.
- Mid-word restart: at cnt=5, apply LOAD 8'h3C -> q=8'h3C, cnt=0, no word_done. Separately, at cnt=7, assert reset -> q=0, cnt=0, no word_done pulse.
